// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Widths here describe the default configuration; the top module is parametrised.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_IDX_W-1:0]  reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

    // Register 0 always reads zero and ignores writes and reserves.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero-register handling, optional write bypass,
// and the pending flag of the selected source.
module regfile_sb_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int BYPASS = 1
) (
    input  logic              rst,
    input  logic [IDX_W-1:0]  src,
    input  logic              load,
    input  logic [IDX_W-1:0]  dest,
    input  logic [DATA_W-1:0] in,
    input  logic [DATA_W-1:0] stored,
    input  logic              stored_pend,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    always_comb begin
        rdata = '0;
        busy  = 1'b0;
        // Reset gating keeps a same-cycle bypassed write from leaking out during rst.
        if (rst || src == IDX_W'(ZERO_REG)) begin
            rdata = '0;
            busy  = 1'b0;
        end else if (BYPASS != 0 && load && dest == src) begin
            rdata = in;
            busy  = 1'b0;
        end else begin
            rdata = stored;
            busy  = stored_pend;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard
// and a registered count of outstanding writes.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int BYPASS   = 1,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [IDX_W-1:0]               dest,
    input  logic [DATA_W-1:0]              in,
    input  logic                           rsv,
    input  logic [IDX_W-1:0]               rsv_idx,
    input  logic                           flush,
    input  logic [NUM_RD-1:0][IDX_W-1:0]   src,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rdata,
    output logic [NUM_RD-1:0]              rbusy,
    output logic [IDX_W:0]                 pend_cnt
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [IDX_W:0]      cnt_nxt;
    logic                wr_ok;
    logic                rsv_ok;
    logic                cnt_inc;
    logic                cnt_dec;

    assign wr_ok  = load && (dest != IDX_W'(ZERO_REG));
    assign rsv_ok = rsv && (rsv_idx != IDX_W'(ZERO_REG));

    always_comb begin
        pend_nxt = pend;
        if (wr_ok)
            pend_nxt[dest] = 1'b0;
        // Reserve is applied after the write so it wins on a collision.
        if (rsv_ok)
            pend_nxt[rsv_idx] = 1'b1;
        if (flush)
            pend_nxt = '0;
    end

    // Incremental count: a reserve of a clear bit adds one; a write clears a
    // set bit unless the same register is re-reserved in this cycle.
    always_comb begin
        cnt_inc = rsv_ok && !pend[rsv_idx];
        cnt_dec = wr_ok && pend[dest] && !(rsv_ok && rsv_idx == dest);
        if (flush)
            cnt_nxt = '0;
        else
            cnt_nxt = pend_cnt + (IDX_W+1)'(cnt_inc) - (IDX_W+1)'(cnt_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok)
                regs[dest] <= in;
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_sb_rdport #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .BYPASS (BYPASS)
        ) u_rdport (
            .rst         (rst),
            .src         (src[p]),
            .load        (load),
            .dest        (dest),
            .in          (in),
            .stored      (regs[src[p]]),
            .stored_pend (pend[src[p]]),
            .rdata       (rdata[p]),
            .busy        (rbusy[p])
        );
    end

    cnt_matches_pend: assert property (@(posedge clk) disable iff (rst)
        pend_cnt == (IDX_W+1)'($countones(pend)));

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised checks of regfile_sb in bypass and non-bypass builds
// sharing one stimulus stream.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NRD = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      load = 1'b0;
    reg_idx_t                  dest = '0;
    data_t                     wdata = '0;
    logic                      rsv = 1'b0;
    reg_idx_t                  rsv_idx = '0;
    logic                      flush = 1'b0;
    logic [NRD-1:0][4:0]       src = '0;
    logic [NRD-1:0][31:0]      rdata_b, rdata_n;
    logic [NRD-1:0]            rbusy_b, rbusy_n;
    logic [5:0]                cnt_b, cnt_n;

    int total = 0;
    int bad   = 0;

    data_t    m_data [32];
    logic [31:0] m_pend;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .load(load), .dest(dest), .in(wdata),
        .rsv(rsv), .rsv_idx(rsv_idx), .flush(flush), .src(src),
        .rdata(rdata_b), .rbusy(rbusy_b), .pend_cnt(cnt_b)
    );

    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .load(load), .dest(dest), .in(wdata),
        .rsv(rsv), .rsv_idx(rsv_idx), .flush(flush), .src(src),
        .rdata(rdata_n), .rbusy(rbusy_n), .pend_cnt(cnt_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_data[i] = '0;
        m_pend = '0;
    endtask

    task automatic model_step();
        if (load && dest != 0) begin
            m_data[dest] = wdata;
            m_pend[dest] = 1'b0;
        end
        if (rsv && rsv_idx != 0) m_pend[rsv_idx] = 1'b1;
        if (flush) m_pend = '0;
    endtask

    task automatic drive(input logic l, input int d, input logic [31:0] w,
                         input logic r, input int ri, input logic f);
        load = l; dest = reg_idx_t'(d); wdata = w;
        rsv = r; rsv_idx = reg_idx_t'(ri); flush = f;
    endtask

    task automatic set_src(input int a, input int b, input int c, input int d);
        src[0] = 5'(a); src[1] = 5'(b); src[2] = 5'(c); src[3] = 5'(d);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Model-based check of every read port on both builds plus both counts.
    task automatic check_model();
        logic [31:0] eb, en;
        logic        bb, bn;
        for (int p = 0; p < NRD; p++) begin
            if (src[p] == 0) begin
                eb = 0; en = 0; bb = 0; bn = 0;
            end else begin
                en = m_data[src[p]];
                bn = m_pend[src[p]];
                if (load && dest == src[p]) begin
                    eb = wdata; bb = 1'b0;
                end else begin
                    eb = en; bb = bn;
                end
            end
            check("rnd_rdata_b", rdata_b[p], eb);
            check("rnd_rbusy_b", 32'(rbusy_b[p]), 32'(bb));
            check("rnd_rdata_n", rdata_n[p], en);
            check("rnd_rbusy_n", 32'(rbusy_n[p]), 32'(bn));
        end
        check("rnd_cnt_b", 32'(cnt_b), 32'($countones(m_pend)));
        check("rnd_cnt_n", 32'(cnt_n), 32'($countones(m_pend)));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int p = 0; p < NRD; p++) begin
            check({tag, "_rdata_b"}, rdata_b[p], 32'h0);
            check({tag, "_rdata_n"}, rdata_n[p], 32'h0);
            check({tag, "_rbusy_b"}, 32'(rbusy_b[p]), 32'h0);
            check({tag, "_rbusy_n"}, 32'(rbusy_n[p]), 32'h0);
        end
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'h0);
        check({tag, "_cnt_n"}, 32'(cnt_n), 32'h0);
    endtask

    initial begin
        model_reset();
        set_src(1, 2, 3, 4);
        drive(1, 1, 32'h1234_5678, 0, 0, 0);
        #2;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #4;

        // Populate state, then pulse reset between edges.
        drive(1, 1, 32'h1111, 1, 2, 0); tick();
        drive(0, 0, 0, 1, 3, 0);        tick();
        check("pre_rst_cnt", 32'(cnt_b), 32'd2);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_pulse");
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Sequential write i -> reg i, then read back on all four ports.
        for (int i = 1; i < 32; i++) begin
            drive(1, i, 32'(i), 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int g = 0; g < 8; g++) begin
            set_src(4*g, 4*g+1, 4*g+2, 4*g+3);
            #1;
            for (int p = 0; p < NRD; p++) begin
                check("seq_rd_b", rdata_b[p], 32'(4*g+p));
                check("seq_rd_n", rdata_n[p], 32'(4*g+p));
            end
        end
        drive(1, 0, 32'hDEAD_BEEF, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        set_src(0, 0, 0, 0); #1;
        check("reg0_b", rdata_b[0], 32'h0);
        check("reg0_n", rdata_n[0], 32'h0);
        check("seq_cnt", 32'(cnt_b), 32'd0);

        // Same-cycle write/read of reg 5.
        set_src(5, 6, 0, 0);
        drive(1, 5, 32'hA5A5_0001, 0, 0, 0); #1;
        check("byp_new", rdata_b[0], 32'hA5A5_0001);
        check("nobyp_old", rdata_n[0], 32'd5);
        check("byp_other", rdata_b[1], 32'd6);
        tick();
        drive(0, 0, 0, 0, 0, 0); #1;
        check("nobyp_next", rdata_n[0], 32'hA5A5_0001);
        check("byp_next", rdata_b[0], 32'hA5A5_0001);

        // Scoreboard: reserve 3, 7, 9.
        drive(0, 0, 0, 1, 3, 0); tick();
        drive(0, 0, 0, 1, 7, 0); tick();
        drive(0, 0, 0, 1, 9, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        set_src(7, 3, 9, 8); #1;
        check("sb_cnt3", 32'(cnt_b), 32'd3);
        check("sb_busy7_b", 32'(rbusy_b[0]), 32'd1);
        check("sb_busy7_n", 32'(rbusy_n[0]), 32'd1);
        check("sb_busy8", 32'(rbusy_b[3]), 32'd0);
        drive(1, 7, 32'h7777, 0, 0, 0); #1;
        check("sb_wr_bypass_busy", 32'(rbusy_b[0]), 32'd0);
        check("sb_wr_nobyp_busy", 32'(rbusy_n[0]), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0); #1;
        check("sb_cnt2", 32'(cnt_b), 32'd2);
        check("sb_busy7_clr", 32'(rbusy_n[0]), 32'd0);
        drive(0, 0, 0, 1, 3, 0); tick();
        drive(0, 0, 0, 0, 0, 0); #1;
        check("sb_rersv_cnt", 32'(cnt_b), 32'd2);
        drive(0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); #1;
        check("sb_rsv0_cnt", 32'(cnt_n), 32'd2);

        // Collision: reg 4 pending, then write+reserve reg 4 together.
        drive(0, 0, 0, 1, 4, 0); tick();
        drive(0, 0, 0, 0, 0, 0); #1;
        check("col_cnt_pre", 32'(cnt_b), 32'd3);
        drive(1, 4, 32'h0000_4444, 1, 4, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        set_src(4, 3, 9, 7); #1;
        check("col_cnt", 32'(cnt_b), 32'd3);
        check("col_data", rdata_n[0], 32'h0000_4444);
        check("col_busy", 32'(rbusy_n[0]), 32'd1);
        // Write+reserve of a non-pending register counts it.
        drive(1, 11, 32'hB0B0, 1, 11, 0); tick();
        drive(0, 0, 0, 0, 0, 0); #1;
        check("col_clear_cnt", 32'(cnt_b), 32'd4);
        // Flush overrides a reserve but the write still lands.
        drive(1, 12, 32'hC0DE, 1, 10, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        set_src(12, 10, 4, 3); #1;
        check("flush_cnt_b", 32'(cnt_b), 32'd0);
        check("flush_cnt_n", 32'(cnt_n), 32'd0);
        check("flush_wr", rdata_n[0], 32'h0000_C0DE);
        check("flush_busy10", 32'(rbusy_n[1]), 32'd0);
        check("flush_busy4", 32'(rbusy_n[2]), 32'd0);

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 3) == 0)
                set_src(int'(dest), int'(rsv_idx), 0, int'($urandom_range(0, 31)));
            else
                set_src(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            #1;
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
